button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Multi-channel push-button conditioner. Each channel synchronises its raw pin,
// normalises polarity (1 = pressed), accepts a level change only after it has
// been stable for DEBOUNCE_CYCLES consecutive samples, and emits one-cycle
// press / release pulses. A per-channel FSM produces auto-repeat pulses while
// a button is held.
//
// Ports
//   clk         : sole clock, all logic on the rising edge
//   reset       : synchronous, active-high reset
//   btn_raw     : [NUM_BTN] asynchronous raw button pins
//   btn_level   : [NUM_BTN] debounced level, 1 = pressed (registered)
//   btn_press   : [NUM_BTN] one-cycle pulse on accepted press (registered)
//   btn_release : [NUM_BTN] one-cycle pulse on accepted release (registered)
//   btn_repeat  : [NUM_BTN] one-cycle auto-repeat pulse while held (registered)
//
// Repeat FSM states
//   state        | meaning
//   -------------+------------------------------------------------------------
//   ST_IDLE      | button released (or auto-repeat disabled)
//   ST_HOLD_WAIT | pressed, counting REPEAT_DELAY cycles to the first repeat
//   ST_REPEATING | held past the delay, pulsing every REPEAT_PERIOD cycles
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);

    // Terminal count is one below the target: the edge on which the counter
    // would reach DEBOUNCE_CYCLES is the edge that accepts the change.
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer reset value is the released pin level.
    localparam logic [NUM_BTN-1:0] SYNC_RST = {NUM_BTN{(ACTIVE_LOW != 0)}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEATING = 2'd2
    } rpt_state_e;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign sample = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch

        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            level_q;
        logic            level_d;
        logic            press_q;
        logic            press_d;
        logic            release_q;
        logic            release_d;
        logic            accept;

        // Stability counter: cleared whenever the sample agrees with the
        // accepted level, so only an unbroken run of differing samples counts.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            accept   = 1'b0;
            if (sample[g] != level_q) begin
                if (db_cnt_q == DB_TC) begin
                    accept  = 1'b1;
                    level_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            press_d   = accept & ~level_q;
            release_d = accept &  level_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;

        if (REPEAT_DELAY > 0) begin : g_rpt

            localparam logic [RPT_W-1:0] RD_TC   = RPT_W'(REPEAT_DELAY - 1);
            localparam logic [RPT_W-1:0] RP_TC   = RPT_W'(REPEAT_PERIOD - 1);
            localparam logic [RPT_W-1:0] RPT_SAT = {RPT_W{1'b1}};

            rpt_state_e       state_q;
            logic [RPT_W-1:0] rpt_cnt_q;
            logic             repeat_q;

            // The press edge only moves IDLE->HOLD_WAIT, and a release edge
            // forces IDLE before any repeat can fire, so repeat never shares a
            // cycle with press or release.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q   <= ST_IDLE;
                    rpt_cnt_q <= '0;
                    repeat_q  <= 1'b0;
                end else begin
                    repeat_q <= 1'b0;
                    if (release_d) begin
                        state_q   <= ST_IDLE;
                        rpt_cnt_q <= '0;
                    end else begin
                        case (state_q)
                            ST_IDLE: begin
                                if (press_d) begin
                                    state_q   <= ST_HOLD_WAIT;
                                    rpt_cnt_q <= '0;
                                end
                            end
                            ST_HOLD_WAIT: begin
                                if (rpt_cnt_q == RD_TC) begin
                                    repeat_q  <= 1'b1;
                                    state_q   <= ST_REPEATING;
                                    rpt_cnt_q <= '0;
                                end else if (rpt_cnt_q != RPT_SAT) begin
                                    rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                                end
                            end
                            ST_REPEATING: begin
                                if (rpt_cnt_q == RP_TC) begin
                                    repeat_q  <= 1'b1;
                                    rpt_cnt_q <= '0;
                                end else if (rpt_cnt_q != RPT_SAT) begin
                                    rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                                end
                            end
                            default: begin
                                state_q   <= ST_IDLE;
                                rpt_cnt_q <= '0;
                            end
                        endcase
                    end
                end
            end

            assign btn_repeat[g] = repeat_q;

        end else begin : g_no_rpt

            assign btn_repeat[g] = 1'b0;

        end
    end

endmodule
